// File: rtl/multicycle_ctrl.sv
// Multicycle MIPS sequencer. Each instruction moves through
// FETCH/DECODE/EXEC/MEM/WB. The FSM drives the datapath write enables and
// mux selects, and it stalls on the shared-memory ready handshake. It halts
// permanently on an illegal instruction or on a memory wait that runs too long.
module multicycle_ctrl #(
    parameter int MEM_TIMEOUT = 16
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] instr,
    input  logic        alu_zero,
    input  logic        mem_ready,
    output logic        pc_write,
    output logic [1:0]  pc_src,
    output logic        ir_write,
    output logic        i_or_d,
    output logic        mem_read,
    output logic        mem_write,
    output logic        reg_write,
    output logic        reg_res,
    output logic        mem_to_reg,
    output logic        ALU_src,
    output logic [5:0]  ALU_ctrl,
    output logic [2:0]  state,
    output logic        illegal,
    output logic        timeout
);

    typedef enum logic [2:0] {
        S_FETCH  = 3'd0,
        S_DECODE = 3'd1,
        S_EXEC   = 3'd2,
        S_MEM    = 3'd3,
        S_WB     = 3'd4,
        S_HALT   = 3'd7
    } state_t;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_BNE   = 6'h05;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;
    localparam logic [5:0] FN_ADD   = 6'h20;
    localparam logic [5:0] FN_SUB   = 6'h22;
    localparam logic [5:0] FN_AND   = 6'h24;
    localparam logic [5:0] FN_OR    = 6'h25;
    localparam logic [5:0] FN_SLT   = 6'h2A;

    // The wait counter value at which the current wait cycle is the last one allowed.
    localparam logic [7:0] WAIT_LIMIT = 8'(MEM_TIMEOUT - 1);

    // Returns 1 when the R-type funct field is one of the supported ALU operations.
    function automatic logic funct_legal(input logic [5:0] f);
        logic ok;
        case (f)
            FN_ADD, FN_SUB, FN_AND, FN_OR, FN_SLT: ok = 1'b1;
            default:                               ok = 1'b0;
        endcase
        return ok;
    endfunction

    state_t      state_r;
    state_t      state_nxt_s;
    logic [7:0]  wait_cnt_r;
    logic [7:0]  wait_cnt_nxt_s;
    logic        illegal_r;
    logic        timeout_r;
    logic        set_illegal_s;
    logic        set_timeout_s;
    logic        wait_limit_s;

    logic [5:0]  opcode_s;
    logic [5:0]  funct_s;
    logic        is_nop_s;
    logic        is_r_s;
    logic        is_addi_s;
    logic        is_lw_s;
    logic        is_sw_s;
    logic        is_beq_s;
    logic        is_bne_s;
    logic        is_j_s;
    logic        is_legal_s;

    logic        pc_write_s;
    logic [1:0]  pc_src_s;
    logic        ir_write_s;
    logic        i_or_d_s;
    logic        mem_read_s;
    logic        mem_write_s;
    logic        reg_write_s;
    logic        reg_res_s;
    logic        mem_to_reg_s;
    logic        alu_src_s;
    logic [5:0]  alu_ctrl_s;

    assign opcode_s     = instr[31:26];
    assign funct_s      = instr[5:0];
    assign wait_limit_s = (wait_cnt_r == WAIT_LIMIT);

    // Decode the instruction register into one-hot instruction classes.
    always_comb begin
        is_nop_s   = (instr == 32'd0);
        is_r_s     = (opcode_s == OP_RTYPE) && funct_legal(funct_s);
        is_addi_s  = (opcode_s == OP_ADDI);
        is_lw_s    = (opcode_s == OP_LW);
        is_sw_s    = (opcode_s == OP_SW);
        is_beq_s   = (opcode_s == OP_BEQ);
        is_bne_s   = (opcode_s == OP_BNE);
        is_j_s     = (opcode_s == OP_J);
        is_legal_s = is_nop_s | is_r_s | is_addi_s | is_lw_s | is_sw_s
                   | is_beq_s | is_bne_s | is_j_s;
    end

    // ALU operand and operation: set up in EXEC and held through MEM and WB so ALU_out stays valid.
    always_comb begin
        alu_src_s  = 1'b0;
        alu_ctrl_s = 6'h00;
        if ((state_r == S_EXEC) || (state_r == S_MEM) || (state_r == S_WB)) begin
            if (is_r_s) begin
                alu_src_s  = 1'b0;
                alu_ctrl_s = funct_s;
            end else if (is_addi_s || is_lw_s || is_sw_s) begin
                alu_src_s  = 1'b1;
                alu_ctrl_s = FN_ADD;
            end else if (is_beq_s || is_bne_s) begin
                alu_src_s  = 1'b0;
                alu_ctrl_s = FN_SUB;
            end else begin
                alu_src_s  = 1'b0;
                alu_ctrl_s = 6'h00;
            end
        end else begin
            alu_src_s  = 1'b0;
            alu_ctrl_s = 6'h00;
        end
    end

    // Next-state, strobe and wait-counter logic for the instruction sequencer.
    always_comb begin
        state_nxt_s    = state_r;
        wait_cnt_nxt_s = wait_cnt_r;
        set_illegal_s  = 1'b0;
        set_timeout_s  = 1'b0;
        pc_write_s     = 1'b0;
        pc_src_s       = 2'd0;
        ir_write_s     = 1'b0;
        i_or_d_s       = 1'b0;
        mem_read_s     = 1'b0;
        mem_write_s    = 1'b0;
        reg_write_s    = 1'b0;
        reg_res_s      = 1'b0;
        mem_to_reg_s   = 1'b0;
        case (state_r)
            S_FETCH: begin
                i_or_d_s   = 1'b0;
                mem_read_s = 1'b1;
                if (mem_ready) begin
                    // A ready on the limit cycle still completes the fetch.
                    ir_write_s  = 1'b1;
                    pc_write_s  = 1'b1;
                    pc_src_s    = 2'd0;
                    state_nxt_s = S_DECODE;
                end else if (wait_limit_s) begin
                    set_timeout_s = 1'b1;
                    state_nxt_s   = S_HALT;
                end else begin
                    wait_cnt_nxt_s = wait_cnt_r + 8'd1;
                end
            end
            S_DECODE: begin
                if (is_nop_s) begin
                    state_nxt_s    = S_FETCH;
                    wait_cnt_nxt_s = 8'd0;
                end else if (!is_legal_s) begin
                    set_illegal_s = 1'b1;
                    state_nxt_s   = S_HALT;
                end else if (is_j_s) begin
                    pc_write_s     = 1'b1;
                    pc_src_s       = 2'd2;
                    state_nxt_s    = S_FETCH;
                    wait_cnt_nxt_s = 8'd0;
                end else begin
                    state_nxt_s = S_EXEC;
                end
            end
            S_EXEC: begin
                if (is_r_s || is_addi_s) begin
                    state_nxt_s = S_WB;
                end else if (is_lw_s || is_sw_s) begin
                    state_nxt_s    = S_MEM;
                    wait_cnt_nxt_s = 8'd0;
                end else if (is_beq_s || is_bne_s) begin
                    pc_src_s       = 2'd1;
                    pc_write_s     = is_beq_s ? alu_zero : ~alu_zero;
                    state_nxt_s    = S_FETCH;
                    wait_cnt_nxt_s = 8'd0;
                end else begin
                    // Only reachable if the IR changed under the FSM; treat it as illegal.
                    set_illegal_s = 1'b1;
                    state_nxt_s   = S_HALT;
                end
            end
            S_MEM: begin
                i_or_d_s    = 1'b1;
                mem_read_s  = is_lw_s;
                mem_write_s = is_sw_s;
                if (mem_ready) begin
                    state_nxt_s    = is_lw_s ? S_WB : S_FETCH;
                    wait_cnt_nxt_s = 8'd0;
                end else if (wait_limit_s) begin
                    set_timeout_s = 1'b1;
                    state_nxt_s   = S_HALT;
                end else begin
                    wait_cnt_nxt_s = wait_cnt_r + 8'd1;
                end
            end
            S_WB: begin
                reg_write_s    = 1'b1;
                reg_res_s      = is_r_s;
                mem_to_reg_s   = is_lw_s;
                state_nxt_s    = S_FETCH;
                wait_cnt_nxt_s = 8'd0;
            end
            S_HALT: begin
                state_nxt_s = S_HALT;
            end
            default: begin
                state_nxt_s = S_HALT;
            end
        endcase
    end

    // State, wait counter and sticky error flags; only reset clears the flags.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_r    <= S_FETCH;
            wait_cnt_r <= 8'd0;
            illegal_r  <= 1'b0;
            timeout_r  <= 1'b0;
        end else begin
            state_r    <= state_nxt_s;
            wait_cnt_r <= wait_cnt_nxt_s;
            if (set_illegal_s) begin
                illegal_r <= 1'b1;
            end else begin
                illegal_r <= illegal_r;
            end
            if (set_timeout_s) begin
                timeout_r <= 1'b1;
            end else begin
                timeout_r <= timeout_r;
            end
        end
    end

    // Drive outputs; while reset is low every strobe and select is forced to 0 immediately.
    always_comb begin
        if (!reset) begin
            pc_write   = 1'b0;
            pc_src     = 2'd0;
            ir_write   = 1'b0;
            i_or_d     = 1'b0;
            mem_read   = 1'b0;
            mem_write  = 1'b0;
            reg_write  = 1'b0;
            reg_res    = 1'b0;
            mem_to_reg = 1'b0;
            ALU_src    = 1'b0;
            ALU_ctrl   = 6'h00;
        end else begin
            pc_write   = pc_write_s;
            pc_src     = pc_src_s;
            ir_write   = ir_write_s;
            i_or_d     = i_or_d_s;
            mem_read   = mem_read_s;
            mem_write  = mem_write_s;
            reg_write  = reg_write_s;
            reg_res    = reg_res_s;
            mem_to_reg = mem_to_reg_s;
            ALU_src    = alu_src_s;
            ALU_ctrl   = alu_ctrl_s;
        end
    end

    assign state   = state_r;
    assign illegal = illegal_r;
    assign timeout = timeout_r;

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Directed bench for multicycle_ctrl: walks hand-built instruction sequences
// and compares every output against hand-computed values each cycle.
module tb_multicycle_ctrl;

    logic        clk;
    logic        reset;
    logic [31:0] instr;
    logic        alu_zero;
    logic        mem_ready;
    logic        pc_write;
    logic [1:0]  pc_src;
    logic        ir_write;
    logic        i_or_d;
    logic        mem_read;
    logic        mem_write;
    logic        reg_write;
    logic        reg_res;
    logic        mem_to_reg;
    logic        ALU_src;
    logic [5:0]  ALU_ctrl;
    logic [2:0]  state;
    logic        illegal;
    logic        timeout;

    int checks = 0;
    int errors = 0;

    localparam logic [31:0] I_ADD  = 32'h012A4020;
    localparam logic [31:0] I_LW   = 32'h8D090004;
    localparam logic [31:0] I_SW   = 32'hAD090008;
    localparam logic [31:0] I_BEQ  = 32'h11090003;
    localparam logic [31:0] I_BNE  = 32'h15090003;
    localparam logic [31:0] I_J    = 32'h08000010;
    localparam logic [31:0] I_BADO = 32'hFC000000;
    localparam logic [31:0] I_BADF = 32'h00000007;

    multicycle_ctrl #(.MEM_TIMEOUT(16)) dut (
        .clk        (clk),
        .reset      (reset),
        .instr      (instr),
        .alu_zero   (alu_zero),
        .mem_ready  (mem_ready),
        .pc_write   (pc_write),
        .pc_src     (pc_src),
        .ir_write   (ir_write),
        .i_or_d     (i_or_d),
        .mem_read   (mem_read),
        .mem_write  (mem_write),
        .reg_write  (reg_write),
        .reg_res    (reg_res),
        .mem_to_reg (mem_to_reg),
        .ALU_src    (ALU_src),
        .ALU_ctrl   (ALU_ctrl),
        .state      (state),
        .illegal    (illegal),
        .timeout    (timeout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Compare all strobes/selects/state as one packed word.
    task automatic check_out(input string tag, input logic pw, input logic [1:0] ps,
                             input logic irw, input logic iod, input logic mr, input logic mw,
                             input logic rw, input logic rr, input logic m2r, input logic as,
                             input logic [5:0] ac, input logic [2:0] st);
        logic [19:0] got;
        logic [19:0] exp;
        got = {pc_write, pc_src, ir_write, i_or_d, mem_read, mem_write, reg_write,
               reg_res, mem_to_reg, ALU_src, ALU_ctrl, state};
        exp = {pw, ps, irw, iod, mr, mw, rw, rr, m2r, as, ac, st};
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: observed %05h expected %05h (pw,ps,irw,iod,mr,mw,rw,rr,m2r,as,ac,st)",
                   tag, got, exp);
        end
    endtask

    task automatic check_flags(input string tag, input logic ill, input logic to);
        checks++;
        assert ({illegal, timeout} === {ill, to}) else begin
            errors++;
            $error("FAIL %s: observed illegal/timeout %b%b expected %b%b", tag, illegal, timeout, ill, to);
        end
    endtask

    // Sample mid-cycle, then advance to just after the next rising edge.
    task automatic step(input string tag, input logic pw, input logic [1:0] ps,
                        input logic irw, input logic iod, input logic mr, input logic mw,
                        input logic rw, input logic rr, input logic m2r, input logic as,
                        input logic [5:0] ac, input logic [2:0] st);
        #3;
        check_out(tag, pw, ps, irw, iod, mr, mw, rw, rr, m2r, as, ac, st);
        @(posedge clk);
        #1;
    endtask

    // One FETCH cycle that completes immediately.
    task automatic fetch_ok(input string tag);
        mem_ready = 1'b1;
        step(tag, 1'b1, 2'd0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 6'h00, 3'd0);
    endtask

    task automatic do_reset();
        reset = 1'b0;
        #2;
        @(posedge clk);
        #1;
        reset = 1'b1;
    endtask

    // Global watchdog so the run always terminates.
    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not reach the end");
        $fatal(1, "watchdog expired");
    end

    initial begin
        reset     = 1'b0;
        instr     = 32'd0;
        alu_zero  = 1'b0;
        mem_ready = 1'b0;
        #12;
        check_out("reset_out", 1'b0, 2'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 6'h00, 3'd0);
        check_flags("reset_flags", 1'b0, 1'b0);
        @(posedge clk);
        #1;
        reset = 1'b1;

        // ADD: FETCH, DECODE, EXEC, WB, back to FETCH
        fetch_ok("add_fetch");
        instr = I_ADD;
        step("add_dec",  1'b0, 2'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 6'h00, 3'd1);
        step("add_exec", 1'b0, 2'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 6'h20, 3'd2);
        step("add_wb",   1'b0, 2'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 6'h20, 3'd4);

        // LW with three wait cycles in MEM
        fetch_ok("lw_fetch");
        instr = I_LW;
        step("lw_dec",   1'b0, 2'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 6'h00, 3'd1);
        step("lw_exec",  1'b0, 2'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 6'h20, 3'd2);
        mem_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step("lw_mem_wait", 1'b0, 2'd0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 6'h20, 3'd3);
        end
        mem_ready = 1'b1;
        step("lw_mem_done", 1'b0, 2'd0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 6'h20, 3'd3);
        step("lw_wb",       1'b0, 2'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 6'h20, 3'd4);

        // BEQ taken, BEQ not taken, BNE not taken
        fetch_ok("beq1_fetch");
        instr = I_BEQ;
        step("beq1_dec",  1'b0, 2'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 6'h00, 3'd1);
        alu_zero = 1'b1;
        step("beq1_exec", 1'b1, 2'd1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 6'h22, 3'd2);
        fetch_ok("beq2_fetch");
        step("beq2_dec",  1'b0, 2'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 6'h00, 3'd1);
        alu_zero = 1'b0;
        step("beq2_exec", 1'b0, 2'd1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 6'h22, 3'd2);
        fetch_ok("bne_fetch");
        instr = I_BNE;
        step("bne_dec",   1'b0, 2'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 6'h00, 3'd1);
        alu_zero = 1'b1;
        step("bne_exec",  1'b0, 2'd1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 6'h22, 3'd2);

        // J then NOP, two cycles each
        fetch_ok("j_fetch");
        instr = I_J;
        step("j_dec",     1'b1, 2'd2, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 6'h00, 3'd1);
        fetch_ok("nop_fetch");
        instr = 32'd0;
        step("nop_dec",   1'b0, 2'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 6'h00, 3'd1);

        // SW interrupted by reset during a MEM wait
        fetch_ok("sw_fetch");
        instr = I_SW;
        step("sw_dec",    1'b0, 2'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 6'h00, 3'd1);
        step("sw_exec",   1'b0, 2'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 6'h20, 3'd2);
        mem_ready = 1'b0;
        #3;
        check_out("sw_mem",     1'b0, 2'd0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 6'h20, 3'd3);
        #1;
        reset = 1'b0;
        #1;
        check_out("sw_rst_drop", 1'b0, 2'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 6'h00, 3'd0);
        @(posedge clk);
        #1;
        reset = 1'b1;
        check_flags("sw_rst_flags", 1'b0, 1'b0);
        step("sw_refetch", 1'b0, 2'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 6'h00, 3'd0);

        // Illegal opcode 0x3F: HALT with zero strobes for 20 cycles
        fetch_ok("bado_fetch");
        instr = I_BADO;
        step("bado_dec",  1'b0, 2'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 6'h00, 3'd1);
        check_flags("bado_flags", 1'b1, 1'b0);
        for (int i = 0; i < 20; i++) begin
            mem_ready = i[0];
            step("bado_halt", 1'b0, 2'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 6'h00, 3'd7);
        end
        do_reset();
        check_flags("bado_cleared", 1'b0, 1'b0);

        // Illegal R-type funct 0x07
        fetch_ok("badf_fetch");
        instr = I_BADF;
        step("badf_dec",  1'b0, 2'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 6'h00, 3'd1);
        step("badf_halt", 1'b0, 2'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 6'h00, 3'd7);
        check_flags("badf_flags", 1'b1, 1'b0);
        do_reset();

        // Fetch timeout: 16 wait cycles then HALT
        mem_ready = 1'b0;
        for (int i = 0; i < 16; i++) begin
            step("to_wait", 1'b0, 2'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 6'h00, 3'd0);
        end
        step("to_halt",   1'b0, 2'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 6'h00, 3'd7);
        check_flags("to_flags", 1'b0, 1'b1);
        do_reset();

        // Ready arriving on the limit cycle completes the fetch normally
        mem_ready = 1'b0;
        for (int i = 0; i < 15; i++) begin
            step("lim_wait", 1'b0, 2'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 6'h00, 3'd0);
        end
        fetch_ok("lim_fetch");
        instr = 32'd0;
        step("lim_dec",   1'b0, 2'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 6'h00, 3'd1);
        check_flags("lim_flags", 1'b0, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
